// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: difference = a - b - bin, CHUNK bits per clock, LSB chunk first.
// Optional signed-overflow output ovf is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] difference,
  output logic             borrow,
  output logic             zero
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             chain_q, chain_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;
  logic [CHUNK-1:0] slice_c;
  logic             bchain_c;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf_q, ovf_d;
  logic             msb_bin_c;
`endif

  // One CHUNK-wide slice of full subtractors fed by the carried borrow.
  always_comb begin
    slice_c  = '0;
    bchain_c = chain_q;
`ifdef SERIAL_SUB_OVF_EN
    msb_bin_c = 1'b0;
`endif
    for (int i = 0; i < int'(CHUNK); i++) begin
      slice_c[i] = a_sh_q[i] ^ b_sh_q[i] ^ bchain_c;
`ifdef SERIAL_SUB_OVF_EN
      if (i == int'(CHUNK) - 1) msb_bin_c = bchain_c;
`endif
      bchain_c = (~a_sh_q[i] & b_sh_q[i]) | (~a_sh_q[i] & bchain_c) | (b_sh_q[i] & bchain_c);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    chain_d  = chain_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
`ifdef SERIAL_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          chain_d = bin;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_sh_d  = a_sh_q >> CHUNK;
        b_sh_d  = b_sh_q >> CHUNK;
        res_d   = (res_q >> CHUNK) | (WIDTH'(slice_c) << (WIDTH - CHUNK));
        chain_d = bchain_c;
        count_d = count_q + CW'(1);
        if (count_q == CW'(N - 1)) begin
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          diff_d   = res_d;
          borrow_d = bchain_c;
          zero_d   = (res_d == '0);
`ifdef SERIAL_SUB_OVF_EN
          ovf_d    = msb_bin_c ^ bchain_c;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      chain_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      chain_q  <= chain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign difference = diff_q;
  assign borrow     = borrow_q;
  assign zero       = zero_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed + random bench for serial_subtractor: 8x1, 16x4 and 8x8 instances sharing operand inputs.
// Define SERIAL_SUB_OVF_EN to also exercise the ovf output.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  start_v;
  logic [15:0] a_in, b_in;
  logic        bin_in;

  logic        busy8, done8, borrow8, zero8;
  logic [7:0]  diff8;
  logic        busy16, done16, borrow16, zero16;
  logic [15:0] diff16;
  logic        busyw, donew, borroww, zerow;
  logic [7:0]  diffw;
`ifdef SERIAL_SUB_OVF_EN
  logic        ovf8, ovf16, ovfw;
`endif

  int          n_cmp = 0;
  int          n_err = 0;
  int          cur   = 0;
  logic        cur_busy, cur_done, cur_borrow, cur_zero;
  logic [15:0] cur_diff;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(8), .CHUNK(1)) u_dut8 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_in[7:0]), .b(b_in[7:0]), .bin(bin_in),
    .busy(busy8), .done(done8), .difference(diff8), .borrow(borrow8), .zero(zero8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(16), .CHUNK(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_in), .b(b_in), .bin(bin_in),
    .busy(busy16), .done(done16), .difference(diff16), .borrow(borrow16), .zero(zero16)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf16)
`endif
  );

  serial_subtractor #(.WIDTH(8), .CHUNK(8)) u_dutw (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_in[7:0]), .b(b_in[7:0]), .bin(bin_in),
    .busy(busyw), .done(donew), .difference(diffw), .borrow(borroww), .zero(zerow)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovfw)
`endif
  );

  always_comb begin
    case (cur)
      0: begin
        cur_busy = busy8; cur_done = done8; cur_borrow = borrow8; cur_zero = zero8;
        cur_diff = {8'h00, diff8};
      end
      1: begin
        cur_busy = busy16; cur_done = done16; cur_borrow = borrow16; cur_zero = zero16;
        cur_diff = diff16;
      end
      default: begin
        cur_busy = busyw; cur_done = donew; cur_borrow = borroww; cur_zero = zerow;
        cur_diff = {8'h00, diffw};
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full operation on instance sel; lat is the number of RUN cycles.
  task automatic op(input int sel, input logic [15:0] a, input logic [15:0] b, input logic bi,
                    input int lat, input logic [15:0] ed, input logic eb, input logic ez,
                    input string tag);
    int cyc;
    int nbusy;
    cur = sel;
    @(negedge clk);
    a_in = a; b_in = b; bin_in = bi; start_v = 3'(1 << sel);
    @(negedge clk);
    start_v = '0;
    a_in = 16'($urandom); b_in = 16'($urandom); bin_in = ~bi;
    cyc = 1; nbusy = 0;
    while (!cur_done && cyc < 64) begin
      if (cur_busy) nbusy++;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(lat + 1));
    check({tag, "_busycyc"}, 32'(nbusy), 32'(lat));
    check({tag, "_busy_at_done"}, 32'(cur_busy), 32'd0);
    check({tag, "_diff"}, 32'(cur_diff), 32'(ed));
    check({tag, "_borrow"}, 32'(cur_borrow), 32'(eb));
    check({tag, "_zero"}, 32'(cur_zero), 32'(ez));
    @(negedge clk);
    check({tag, "_done_drop"}, 32'(cur_done), 32'd0);
  endtask

  initial begin
    int cyc;
    int pulses;
    logic [15:0] ra, rb;
    logic        rbi;
    logic [16:0] r;

    rst = 1'b1; start_v = '0; a_in = '0; b_in = '0; bin_in = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_diff", 32'(diff8), 32'd0);
    check("rst_borrow", 32'(borrow8), 32'd0);
    check("rst_zero", 32'(zero8), 32'd0);
    check("rst_diff16", 32'(diff16), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", 32'(ovf8), 32'd0);
`endif
    rst = 1'b0;

    op(0, 16'h05, 16'h03, 1'b0, 8, 16'h02, 1'b0, 1'b0, "t1");
    op(0, 16'h00, 16'h01, 1'b0, 8, 16'hFF, 1'b1, 1'b0, "t2a");
    op(0, 16'h10, 16'h10, 1'b1, 8, 16'hFF, 1'b1, 1'b0, "t2b");
    op(0, 16'h10, 16'h0F, 1'b1, 8, 16'h00, 1'b0, 1'b1, "t2c");

    // Start during RUN is ignored; start in the done cycle is accepted.
    cur = 0;
    @(negedge clk);
    a_in = 16'h05; b_in = 16'h03; bin_in = 1'b0; start_v = 3'b001;
    @(negedge clk);
    start_v = '0; cyc = 1;
    repeat (2) begin @(negedge clk); cyc++; end
    a_in = 16'hAA; b_in = 16'h11; bin_in = 1'b1; start_v = 3'b001;
    check("t4_hold_diff", 32'(diff8), 32'h00);
    check("t4_hold_zero", 32'(zero8), 32'd1);
    @(negedge clk);
    start_v = '0; cyc++;
    while (!done8 && cyc < 64) begin @(negedge clk); cyc++; end
    check("t4_lat", 32'(cyc), 32'd9);
    check("t4_diff", 32'(diff8), 32'h02);
    a_in = 16'h20; b_in = 16'h01; bin_in = 1'b1; start_v = 3'b001;
    @(negedge clk);
    start_v = '0; cyc = 1;
    check("t4_b2b_busy", 32'(busy8), 32'd1);
    check("t4_b2b_hold", 32'(diff8), 32'h02);
    while (!done8 && cyc < 64) begin @(negedge clk); cyc++; end
    check("t4_b2b_lat", 32'(cyc), 32'd9);
    check("t4_b2b_diff", 32'(diff8), 32'h1E);
    check("t4_b2b_borrow", 32'(borrow8), 32'd0);
    @(negedge clk);

    // Asynchronous reset in RUN cycle 4 aborts the operation.
    @(negedge clk);
    a_in = 16'h40; b_in = 16'h01; bin_in = 1'b0; start_v = 3'b001;
    @(negedge clk);
    start_v = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("t5_busy", 32'(busy8), 32'd0);
    check("t5_diff", 32'(diff8), 32'd0);
    check("t5_borrow", 32'(borrow8), 32'd0);
    check("t5_zero", 32'(zero8), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    repeat (12) begin @(negedge clk); if (done8 || busy8) pulses++; end
    check("t5_no_done", 32'(pulses), 32'd0);
    op(0, 16'h40, 16'h01, 1'b0, 8, 16'h3F, 1'b0, 1'b0, "t5_after");

`ifdef SERIAL_SUB_OVF_EN
    op(0, 16'h80, 16'h01, 1'b0, 8, 16'h7F, 1'b0, 1'b0, "t3a");
    check("t3a_ovf", 32'(ovf8), 32'd1);
    op(0, 16'h7F, 16'h01, 1'b0, 8, 16'h7E, 1'b0, 1'b0, "t3b");
    check("t3b_ovf", 32'(ovf8), 32'd0);
    op(0, 16'h7F, 16'h7F, 1'b1, 8, 16'hFF, 1'b1, 1'b0, "t3c");
    check("t3c_ovf", 32'(ovf8), 32'd0);
`endif

    op(1, 16'h1234, 16'h0235, 1'b0, 4, 16'h0FFF, 1'b0, 1'b0, "t6");
    op(1, 16'h0000, 16'hFFFF, 1'b1, 4, 16'h0000, 1'b1, 1'b1, "t6_edge");
    op(2, 16'h05, 16'h03, 1'b0, 1, 16'h02, 1'b0, 1'b0, "w1");
    op(2, 16'hFF, 16'hFF, 1'b1, 1, 16'hFF, 1'b1, 1'b0, "w2");

    for (int i = 0; i < 1000; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rbi = 1'($urandom);
      r   = {1'b0, ra} - {1'b0, rb} - 17'(rbi);
      op(1, ra, rb, rbi, 4, r[15:0], r[16], r[15:0] == 16'h0000, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
